// File: rtl/operand_stream_bank.sv
// operand_stream_bank: buffers W and X from a serial element stream, then
// replays them as outer-product operands (column k of W, row k of X) to a
// MAX_DIM x MAX_DIM MAC array with valid/ready framing.
module operand_stream_bank #(
  parameter int DATA_W  = 4,
  parameter int MAX_DIM = 3,
  localparam int DIM_W  = $clog2(MAX_DIM + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [DIM_W-1:0]           row_w,
  input  logic [DIM_W-1:0]           col_w,
  input  logic [DIM_W-1:0]           row_x,
  input  logic [DIM_W-1:0]           col_x,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  output logic [MAX_DIM*DATA_W-1:0]  w_out,
  output logic [MAX_DIM*DATA_W-1:0]  x_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_first,
  output logic                       out_last,
  output logic [MAX_DIM*MAX_DIM-1:0] mac_en,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  // Storage index width; counters carry one extra value so they can hold MAX_DIM.
  localparam int IDX_W = $clog2(MAX_DIM);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_LOAD_X, S_STREAM, S_DONE} state_t;

  state_t           r_state;
  logic [DIM_W-1:0] r_row_w, r_col_w, r_row_x, r_col_x;
  logic [DIM_W-1:0] r_row_cnt, r_col_cnt, r_k;
  logic             r_err;
  logic [DATA_W-1:0] r_w_mem [MAX_DIM][MAX_DIM];
  logic [DATA_W-1:0] r_x_mem [MAX_DIM][MAX_DIM];

  logic w_dims_ok;
  logic w_stream;
  logic w_last_k;

  assign w_dims_ok = (row_w != '0) && (row_w <= DIM_W'(MAX_DIM)) &&
                     (col_w != '0) && (col_w <= DIM_W'(MAX_DIM)) &&
                     (row_x != '0) && (row_x <= DIM_W'(MAX_DIM)) &&
                     (col_x != '0) && (col_x <= DIM_W'(MAX_DIM)) &&
                     (col_w == row_x);
  assign w_stream  = (r_state == S_STREAM);
  assign w_last_k  = (r_k == r_col_w - DIM_W'(1));

  // Job sequencing: dimension check, row/column load counters, beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_row_w   <= '0;
      r_col_w   <= '0;
      r_row_x   <= '0;
      r_col_x   <= '0;
      r_row_cnt <= '0;
      r_col_cnt <= '0;
      r_k       <= '0;
      r_err     <= 1'b0;
      for (int i = 0; i < MAX_DIM; i++) begin
        for (int j = 0; j < MAX_DIM; j++) begin
          r_w_mem[i][j] <= '0;
          r_x_mem[i][j] <= '0;
        end
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_dims_ok) begin
              r_row_w   <= row_w;
              r_col_w   <= col_w;
              r_row_x   <= row_x;
              r_col_x   <= col_x;
              r_row_cnt <= '0;
              r_col_cnt <= '0;
              r_k       <= '0;
              r_err     <= 1'b0;
              r_state   <= S_LOAD_W;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_LOAD_W: begin
          if (in_valid) begin
            r_w_mem[r_row_cnt[IDX_W-1:0]][r_col_cnt[IDX_W-1:0]] <= in_data;
            if (r_col_cnt == r_col_w - DIM_W'(1)) begin
              r_col_cnt <= '0;
              if (r_row_cnt == r_row_w - DIM_W'(1)) begin
                r_row_cnt <= '0;
                r_state   <= S_LOAD_X;
              end else begin
                r_row_cnt <= r_row_cnt + DIM_W'(1);
              end
            end else begin
              r_col_cnt <= r_col_cnt + DIM_W'(1);
            end
          end
        end
        S_LOAD_X: begin
          if (in_valid) begin
            r_x_mem[r_row_cnt[IDX_W-1:0]][r_col_cnt[IDX_W-1:0]] <= in_data;
            if (r_col_cnt == r_col_x - DIM_W'(1)) begin
              r_col_cnt <= '0;
              if (r_row_cnt == r_row_x - DIM_W'(1)) begin
                r_row_cnt <= '0;
                r_k       <= '0;
                r_state   <= S_STREAM;
              end else begin
                r_row_cnt <= r_row_cnt + DIM_W'(1);
              end
            end else begin
              r_col_cnt <= r_col_cnt + DIM_W'(1);
            end
          end
        end
        S_STREAM: begin
          if (out_ready) begin
            if (w_last_k) begin
              r_k     <= '0;
              r_state <= S_DONE;
            end else begin
              r_k <= r_k + DIM_W'(1);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Control outputs are pure decodes of the state register.
  assign in_ready  = (r_state == S_LOAD_W) || (r_state == S_LOAD_X);
  assign out_valid = w_stream;
  assign out_first = w_stream && (r_k == '0);
  assign out_last  = w_stream && w_last_k;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign err       = r_err;

  // Operand lanes and MAC enables; inactive lanes are forced to zero.
  generate
    for (genvar gi = 0; gi < MAX_DIM; gi++) begin : g_lane
      assign w_out[gi*DATA_W +: DATA_W] = (w_stream && (DIM_W'(gi) < r_row_w)) ?
                                          r_w_mem[gi][r_k[IDX_W-1:0]] : '0;
      assign x_out[gi*DATA_W +: DATA_W] = (w_stream && (DIM_W'(gi) < r_col_x)) ?
                                          r_x_mem[r_k[IDX_W-1:0]][gi] : '0;
      for (genvar gj = 0; gj < MAX_DIM; gj++) begin : g_mac
        assign mac_en[gi*MAX_DIM+gj] = w_stream && (DIM_W'(gi) < r_row_w) &&
                                       (DIM_W'(gj) < r_col_x);
      end
    end
  endgenerate

endmodule

// File: tb/tb_operand_stream_bank.sv
// Directed bench for operand_stream_bank (DATA_W=4, MAX_DIM=3) plus a
// randomised scoreboard run on an 8-bit, 8x8 instance.
module tb_operand_stream_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Small instance
  logic        start;
  logic [1:0]  row_w, col_w, row_x, col_x;
  logic        in_valid;
  logic [3:0]  in_data;
  logic        in_ready;
  logic [11:0] w_out, x_out;
  logic        out_valid, out_ready, out_first, out_last;
  logic [8:0]  mac_en;
  logic        busy, done, err;

  // Wide instance
  logic        start8;
  logic [3:0]  row_w8, col_w8, row_x8, col_x8;
  logic        in_valid8;
  logic [7:0]  in_data8;
  logic        in_ready8;
  logic [63:0] w_out8, x_out8;
  logic        out_valid8, out_ready8, out_first8, out_last8;
  logic [63:0] mac_en8;
  logic        busy8, done8, err8;

  int n_assert = 0;
  int n_fail   = 0;

  operand_stream_bank #(.DATA_W(4), .MAX_DIM(3)) dut (
    .clk(clk), .rst(rst), .start(start),
    .row_w(row_w), .col_w(col_w), .row_x(row_x), .col_x(col_x),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .w_out(w_out), .x_out(x_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_first(out_first), .out_last(out_last), .mac_en(mac_en),
    .busy(busy), .done(done), .err(err)
  );

  operand_stream_bank #(.DATA_W(8), .MAX_DIM(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8),
    .row_w(row_w8), .col_w(col_w8), .row_x(row_x8), .col_x(col_x8),
    .in_valid(in_valid8), .in_data(in_data8), .in_ready(in_ready8),
    .w_out(w_out8), .x_out(x_out8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out_first(out_first8), .out_last(out_last8), .mac_en(mac_en8),
    .busy(busy8), .done(done8), .err(err8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push n consecutive values starting at first_val; optional idle cycle before each.
  task automatic load(input int first_val, input int n, input bit stall);
    for (int e = 0; e < n; e++) begin
      if (stall) begin
        in_valid = 1'b0;
        in_data  = 4'hF;
        tick();
      end
      in_valid = 1'b1;
      in_data  = 4'(first_val + e);
      tick();
    end
    in_valid = 1'b0;
    in_data  = 4'h0;
  endtask

  task automatic beat(input string tag, input logic [11:0] ew, input logic [11:0] ex,
                      input logic ef, input logic el, input logic [8:0] em);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_w"}, 64'(w_out), 64'(ew));
    chk({tag, "_x"}, 64'(x_out), 64'(ex));
    chk({tag, "_first_last"}, 64'({out_first, out_last}), 64'({ef, el}));
    chk({tag, "_mac"}, 64'(mac_en), 64'(em));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_flags"}, 64'({busy, in_ready, out_valid, out_first, out_last, done}), 64'd0);
    chk({tag, "_w"}, 64'(w_out), 64'd0);
    chk({tag, "_x"}, 64'(x_out), 64'd0);
    chk({tag, "_mac"}, 64'(mac_en), 64'd0);
  endtask

  task automatic set_dims(input logic [1:0] a, input logic [1:0] b,
                          input logic [1:0] c, input logic [1:0] d);
    row_w = a; col_w = b; row_x = c; col_x = d;
  endtask

  int W [8][8];
  int X [8][8];
  int C [8][8];

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    set_dims(2'd0, 2'd0, 2'd0, 2'd0);
    start8 = 1'b0; in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b0;
    row_w8 = '0; col_w8 = '0; row_x8 = '0; col_x8 = '0;

    // Reset held 3 cycles under random activity
    for (int c = 0; c < 3; c++) begin
      start    = 1'($urandom);
      in_valid = 1'($urandom);
      in_data  = 4'($urandom);
      set_dims(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
      tick();
      chk_quiet("rst_hold");
      chk("rst_hold_err", 64'(err), 64'd0);
    end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    tick();

    // 2x3 * 3x2, no stalls
    out_ready = 1'b1;
    set_dims(2'd2, 2'd3, 2'd3, 2'd2);
    start = 1'b1;
    tick();                                   // cycle 1 after start
    start = 1'b0;
    chk("j1_busy_ready", 64'({busy, in_ready}), 64'h3);
    load(1, 12, 1'b0);                        // now cycle 13
    beat("j1_b0", 12'h041, 12'h087, 1'b1, 1'b0, 9'h01B);
    tick();
    beat("j1_b1", 12'h052, 12'h0A9, 1'b0, 1'b0, 9'h01B);
    tick();
    beat("j1_b2", 12'h063, 12'h0CB, 1'b0, 1'b1, 9'h01B);
    tick();                                   // cycle 16
    chk("j1_done", 64'({done, busy, out_valid}), 64'h6);
    chk("j1_done_mac", 64'(mac_en), 64'd0);
    tick();
    chk("j1_end", 64'({done, busy}), 64'd0);

    // Same job with input and output back-pressure
    start = 1'b1;
    tick();
    start = 1'b0;
    load(1, 12, 1'b1);
    beat("bp_b0", 12'h041, 12'h087, 1'b1, 1'b0, 9'h01B);
    tick();
    out_ready = 1'b0;
    beat("bp_b1", 12'h052, 12'h0A9, 1'b0, 1'b0, 9'h01B);
    tick();
    beat("bp_b1_hold1", 12'h052, 12'h0A9, 1'b0, 1'b0, 9'h01B);
    tick();
    out_ready = 1'b1;
    beat("bp_b1_hold2", 12'h052, 12'h0A9, 1'b0, 1'b0, 9'h01B);
    tick();
    beat("bp_b2", 12'h063, 12'h0CB, 1'b0, 1'b1, 9'h01B);
    tick();
    chk("bp_done", 64'({done, out_valid}), 64'h2);
    tick();
    chk("bp_done_once", 64'({done, busy}), 64'd0);

    // Reset in the middle of LOAD_X
    start = 1'b1;
    tick();
    start = 1'b0;
    load(1, 8, 1'b0);
    chk("mid_loadx_busy", 64'({busy, in_ready}), 64'h3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_quiet("mid_rst");
    tick();

    // Full 3x3 * 3x3 with starts pulsed during STREAM
    set_dims(2'd3, 2'd3, 2'd3, 2'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    load(1, 9, 1'b0);
    load(6, 9, 1'b0);
    beat("f_b0", 12'h741, 12'h876, 1'b1, 1'b0, 9'h1FF);
    tick();
    beat("f_b1", 12'h852, 12'hBA9, 1'b0, 1'b0, 9'h1FF);
    set_dims(2'd1, 2'd1, 2'd1, 2'd1);
    start = 1'b1;
    tick();
    beat("f_b2", 12'h963, 12'hEDC, 1'b0, 1'b1, 9'h1FF);
    set_dims(2'd0, 2'd1, 2'd1, 2'd1);
    tick();
    start = 1'b0;
    chk("f_done", 64'({done, err}), 64'h2);
    tick();
    chk_quiet("f_after");
    tick();
    chk("f_no_restart", 64'({busy, err}), 64'd0);

    // Illegal dims: col_w != row_x
    set_dims(2'd2, 2'd2, 2'd3, 2'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ill_err", 64'({err, busy, in_ready}), 64'h4);
    tick();
    chk("ill_sticky", 64'(err), 64'd1);

    // Legal 1x1 job clears err
    set_dims(2'd1, 2'd1, 2'd1, 2'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("one_start", 64'({err, busy}), 64'h1);
    load(15, 1, 1'b0);
    load(15, 1, 1'b0);
    beat("one_b0", 12'h00F, 12'h00F, 1'b1, 1'b1, 9'h001);
    tick();
    chk("one_done", 64'(done), 64'd1);
    tick();

    // row_w = 0 is illegal
    set_dims(2'd0, 2'd1, 2'd1, 2'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_err", 64'({err, busy}), 64'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_clears_err", 64'(err), 64'd0);
    tick();

    // Wide instance: random legal jobs, products rebuilt from beats
    for (int job = 0; job < 200; job++) begin
      int r, m, c, total, idx, beats;
      bit acc, ok, got_done;
      r = $urandom_range(1, 8);
      m = $urandom_range(1, 8);
      c = $urandom_range(1, 8);
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++) begin
          W[i][j] = $urandom_range(0, 255);
          X[i][j] = $urandom_range(0, 255);
          C[i][j] = -1;
        end
      row_w8 = 4'(r); col_w8 = 4'(m); row_x8 = 4'(m); col_x8 = 4'(c);
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      total = r * m + m * c;
      idx = 0;
      for (int cyc = 0; cyc < 400 && idx < total; cyc++) begin
        in_valid8 = ($urandom_range(0, 3) != 0);
        in_data8  = (idx < r * m) ? 8'(W[idx / m][idx % m])
                                  : 8'(X[(idx - r * m) / c][(idx - r * m) % c]);
        acc = in_valid8 && in_ready8;
        tick();
        if (acc) idx++;
      end
      in_valid8 = 1'b0;
      beats = 0;
      ok = 1'b1;
      got_done = 1'b0;
      for (int cyc = 0; cyc < 200 && !got_done; cyc++) begin
        out_ready8 = ($urandom_range(0, 2) != 0);
        if (out_valid8 && out_ready8) begin
          if (out_first8 !== (beats == 0)) ok = 1'b0;
          if (out_last8 !== (beats == m - 1)) ok = 1'b0;
          for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
              int p;
              p = int'(w_out8[i*8 +: 8]) * int'(x_out8[j*8 +: 8]);
              if (out_first8) C[i][j] = p;
              else C[i][j] += p;
              if (mac_en8[i*8+j] !== ((i < r) && (j < c))) ok = 1'b0;
            end
          for (int i = r; i < 8; i++) if (w_out8[i*8 +: 8] !== 8'h0) ok = 1'b0;
          for (int j = c; j < 8; j++) if (x_out8[j*8 +: 8] !== 8'h0) ok = 1'b0;
          beats++;
        end
        if (done8) got_done = 1'b1;
        tick();
      end
      out_ready8 = 1'b0;
      for (int i = 0; i < r; i++)
        for (int j = 0; j < c; j++) begin
          int s;
          s = 0;
          for (int k = 0; k < m; k++) s += W[i][k] * X[k][j];
          if (C[i][j] != s) ok = 1'b0;
        end
      chk("p8_loaded", 64'(idx), 64'(total));
      chk("p8_beats", 64'(beats), 64'(m));
      chk("p8_done", 64'(got_done), 64'd1);
      chk("p8_product", 64'(ok), 64'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
